vga_pll_supervisor: RTL and testbench

Lock supervisor and reset sequencer for the iCE40 VGA pixel-clock PLL (100 MHz in, ~25.3 MHz out).
- Runs on the 100 MHz board clock, which stays valid while the PLL is unlocked.
- Drives the PLL RESETB pin and watches its LOCK output.
- Releases the pixel-domain reset only after lock has been stable for a set time.
- Retries the PLL on lock timeout, counts lock losses, and latches a fault after repeated failure.

---
 rtl/vga_pll_supervisor.sv | 139 +++++++++++++
 tb/tb_vga_pll_supervisor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pll_supervisor.sv
// vga_pll_supervisor: lock supervisor and reset sequencer for the VGA pixel-clock PLL.
// Runs on the always-valid board clock, pulses PLL RESETB, waits for a stable
// synchronized lock before releasing the pixel domain, retries on timeout and
// latches a fault after MAX_RETRIES failed re-resets.
// Optional build macro: VGA_PLL_SUP_GLITCH_FILTER_EN (filters short lock drops in RUN).
module vga_pll_supervisor #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned LOCK_TIMEOUT       = 1000000,
    parameter int unsigned RESET_PULSE        = 16,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned GLITCH_CYCLES      = 4
) (
    input  logic                                 clock_in,
    input  logic                                 reset,
    input  logic                                 pll_locked,
    output logic                                 pll_resetb,
    output logic                                 pixel_reset,
    output logic                                 pll_ready,
    output logic                                 fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_count,
    output logic [7:0]                           loss_count
);

    localparam int unsigned CNT_MAX0 = (LOCK_TIMEOUT > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > RESET_PULSE) ? CNT_MAX0 : RESET_PULSE;
    localparam int unsigned CNT_W    = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned RC_W     = $clog2(MAX_RETRIES+1);

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [RC_W-1:0]   retry_nx;
    logic [7:0]        loss_nx;
    logic [1:0]        sync_q;
    logic              lock_s;
    logic              lock_loss;

    assign lock_s = sync_q[1];

    // Two-flop synchronizer for the asynchronous PLL LOCK signal
    always_ff @(posedge clock_in) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], pll_locked};
    end

`ifdef VGA_PLL_SUP_GLITCH_FILTER_EN
    localparam int unsigned GL_W = ($clog2(GLITCH_CYCLES) > 0) ? $clog2(GLITCH_CYCLES) : 1;
    logic [GL_W-1:0] glitch_cnt;

    // Loss in RUN only after GLITCH_CYCLES consecutive low samples of lock_s
    assign lock_loss = !lock_s && (glitch_cnt == GL_W'(GLITCH_CYCLES-1));

    // Consecutive-low counter, active only while in RUN
    always_ff @(posedge clock_in) begin
        if (reset)                                 glitch_cnt <= '0;
        else if (state != RUN || lock_s || lock_loss) glitch_cnt <= '0;
        else                                       glitch_cnt <= glitch_cnt + GL_W'(1);
    end
`else
    assign lock_loss = !lock_s;
`endif

    // State, shared counter and retry/loss bookkeeping registers
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state       <= PLL_RESET;
            cnt         <= '0;
            retry_count <= '0;
            loss_count  <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            retry_count <= retry_nx;
            loss_count  <= loss_nx;
        end
    end

    // Next-state logic; lock loss wins in STABLE, lock wins over timeout in WAIT_LOCK
    always_comb begin
        state_nx = state;
        retry_nx = retry_count;
        loss_nx  = loss_count;
        unique case (state)
            PLL_RESET: begin
                if (cnt == CNT_W'(RESET_PULSE-1)) state_nx = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nx = STABLE;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT-1)) begin
                    if (retry_count == RC_W'(MAX_RETRIES)) begin
                        state_nx = FAULT;
                    end else begin
                        retry_nx = retry_count + RC_W'(1);
                        state_nx = PLL_RESET;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nx = WAIT_LOCK;
                end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES-1)) begin
                    state_nx = RUN;
                    retry_nx = '0;
                end
            end
            RUN: begin
                if (lock_loss) begin
                    state_nx = WAIT_LOCK;
                    if (loss_count != '1) loss_nx = loss_count + 8'd1;
                end
            end
            FAULT: state_nx = FAULT;
            default: state_nx = PLL_RESET;
        endcase
    end

    // Counter clears on any state change and only advances in timed states
    always_comb begin
        cnt_nx = cnt;
        if (state_nx != state)
            cnt_nx = '0;
        else if (state == PLL_RESET || state == WAIT_LOCK || state == STABLE)
            cnt_nx = cnt + CNT_W'(1);
    end

    assign pll_resetb  = !(state == PLL_RESET || state == FAULT);
    assign pixel_reset = (state != RUN);
    assign pll_ready   = (state == RUN);
    assign fault       = (state == FAULT);

endmodule

// File: tb/tb_vga_pll_supervisor.sv
// tb_vga_pll_supervisor: directed scoreboard bench for vga_pll_supervisor.
// Cycle N is the value sampled on the falling edge just before rising edge N,
// where rising edge 0 is the first edge with reset deasserted.
module tb_vga_pll_supervisor;

    localparam int unsigned LS = 8;
    localparam int unsigned TO = 32;
    localparam int unsigned RP = 4;
    localparam int unsigned MR = 2;
    localparam int unsigned GC = 3;
`ifdef VGA_PLL_SUP_GLITCH_FILTER_EN
    localparam int GL = 3;
`else
    localparam int GL = 1;
`endif

    localparam int S_RESETB = 0;
    localparam int S_PIXRST = 1;
    localparam int S_READY  = 2;
    localparam int S_FAULT  = 3;
    localparam int S_RETRY  = 4;
    localparam int S_LOSS   = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       pll_resetb, pixel_reset, pll_ready, fault;
    logic [1:0] retry_count;
    logic [7:0] loss_count;

    vga_pll_supervisor #(
        .LOCK_STABLE_CYCLES(LS),
        .LOCK_TIMEOUT(TO),
        .RESET_PULSE(RP),
        .MAX_RETRIES(MR),
        .GLITCH_CYCLES(GC)
    ) dut (
        .clock_in(clk),
        .reset(reset),
        .pll_locked(pll_locked),
        .pll_resetb(pll_resetb),
        .pixel_reset(pixel_reset),
        .pll_ready(pll_ready),
        .fault(fault),
        .retry_count(retry_count),
        .loss_count(loss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_RESETB: observe = {31'd0, pll_resetb};
            S_PIXRST: observe = {31'd0, pixel_reset};
            S_READY:  observe = {31'd0, pll_ready};
            S_FAULT:  observe = {31'd0, fault};
            S_RETRY:  observe = {30'd0, retry_count};
            default:  observe = {24'd0, loss_count};
        endcase
    endfunction

    task automatic expect_at(input int c, input int sig, input int val, input string tag);
        sb.push_back('{c, sig, val, tag});
    endtask

    task automatic check_due();
        logic [31:0] obs;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                obs = observe(sb[i].sig);
                n_assert++;
                assert (obs === 32'(sb[i].val)) else begin
                    n_fail++;
                    $error("FAIL %s cyc %0d: observed %0d expected %0d", sb[i].tag, cyc, obs, sb[i].val);
                end
                sb.delete(i);
            end
        end
    endtask

    task automatic flush();
        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL unconsumed_expectations: observed %0d pending expected 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic do_reset(input logic lk);
        pll_locked = lk;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        check_due();
    endtask

    task automatic run_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            check_due();
        end
    endtask

    initial begin
        int c, d, g, r;
        reset = 1'b1;
        pll_locked = 1'b0;
        cyc = 0;

        // Lock present throughout: reset values, pulse width, RUN at cycle 13
        expect_at(0,  S_RESETB, 0, "rst_resetb");
        expect_at(0,  S_PIXRST, 1, "rst_pixrst");
        expect_at(0,  S_READY,  0, "rst_ready");
        expect_at(0,  S_FAULT,  0, "rst_fault");
        expect_at(0,  S_RETRY,  0, "rst_retry");
        expect_at(0,  S_LOSS,   0, "rst_loss");
        expect_at(3,  S_RESETB, 0, "pulse_end_low");
        expect_at(4,  S_RESETB, 1, "pulse_release");
        expect_at(12, S_READY,  0, "ready_not_early");
        expect_at(13, S_READY,  1, "ready_c13");
        expect_at(13, S_PIXRST, 0, "pixrst_c13");
        expect_at(13, S_RETRY,  0, "retry_run");
        do_reset(1'b1);
        run_to(20);

`ifdef VGA_PLL_SUP_GLITCH_FILTER_EN
        // Two-cycle drop is filtered, three-cycle drop is a loss
        c = cyc;
        expect_at(c+3, S_READY, 1, "flt2_ready_a");
        expect_at(c+4, S_READY, 1, "flt2_ready_b");
        expect_at(c+6, S_READY, 1, "flt2_ready_c");
        expect_at(c+6, S_LOSS,  0, "flt2_loss");
        pll_locked = 1'b0;
        run_to(c+2);
        pll_locked = 1'b1;
        run_to(c+10);
        d = cyc;
        expect_at(d+4,  S_READY, 1, "flt3_ready_hold");
        expect_at(d+5,  S_READY, 0, "flt3_ready_drop");
        expect_at(d+5,  S_LOSS,  1, "flt3_loss");
        expect_at(d+13, S_READY, 0, "flt3_not_early");
        expect_at(d+14, S_READY, 1, "flt3_rerun");
        pll_locked = 1'b0;
        run_to(d+3);
        pll_locked = 1'b1;
        run_to(d+16);
`else
        // Single-cycle drop in RUN is a loss; re-enter RUN 9 cycles after lock_s returns
        c = cyc;
        expect_at(c+2,  S_READY,  1, "loss_ready_hold");
        expect_at(c+3,  S_READY,  0, "loss_ready_drop");
        expect_at(c+3,  S_PIXRST, 1, "loss_pixrst");
        expect_at(c+3,  S_LOSS,   1, "loss_count1");
        expect_at(c+3,  S_RESETB, 1, "loss_no_pll_reset");
        expect_at(c+11, S_READY,  0, "loss_not_early");
        expect_at(c+12, S_READY,  1, "loss_rerun");
        expect_at(c+12, S_RETRY,  0, "loss_retry0");
        pll_locked = 1'b0;
        run_to(c+1);
        pll_locked = 1'b1;
        run_to(c+14);
`endif

        // Two more losses, then reset mid-RUN with loss_count=3
        for (int k = 0; k < 2; k++) begin
            g = cyc;
            pll_locked = 1'b0;
            run_to(g+GL);
            pll_locked = 1'b1;
            run_to(g+20);
        end
        expect_at(cyc+1, S_LOSS,  3, "loss_count3");
        expect_at(cyc+1, S_READY, 1, "ready_before_rst");
        run_to(cyc+1);
        r = cyc;
        expect_at(r+1, S_RESETB, 0, "midrst_resetb");
        expect_at(r+1, S_PIXRST, 1, "midrst_pixrst");
        expect_at(r+1, S_READY,  0, "midrst_ready");
        expect_at(r+1, S_LOSS,   0, "midrst_loss");
        reset = 1'b1;
        run_to(r+1);
        reset = 1'b0;
        run_to(r+3);

        // Drop in STABLE at cnt=5 forces a full fresh stable window
        flush();
        expect_at(12, S_READY,  0, "stb_ready_c12");
        expect_at(13, S_READY,  0, "stb_ready_c13");
        expect_at(13, S_PIXRST, 1, "stb_pixrst_c13");
        expect_at(19, S_READY,  0, "stb_not_early");
        expect_at(20, S_READY,  1, "stb_run");
        expect_at(20, S_RETRY,  0, "stb_retry0");
        do_reset(1'b1);
        run_to(8);
        pll_locked = 1'b0;
        run_to(9);
        pll_locked = 1'b1;
        run_to(22);

        // No lock ever: three PLL pulses, then sticky FAULT at cycle 108
        flush();
        expect_at(3,   S_RESETB, 0, "nl_pulse1_end");
        expect_at(4,   S_RESETB, 1, "nl_wait1");
        expect_at(35,  S_RESETB, 1, "nl_wait1_end");
        expect_at(35,  S_RETRY,  0, "nl_retry0");
        expect_at(36,  S_RESETB, 0, "nl_pulse2");
        expect_at(36,  S_RETRY,  1, "nl_retry1");
        expect_at(39,  S_RESETB, 0, "nl_pulse2_end");
        expect_at(40,  S_RESETB, 1, "nl_wait2");
        expect_at(72,  S_RESETB, 0, "nl_pulse3");
        expect_at(72,  S_RETRY,  2, "nl_retry2");
        expect_at(75,  S_RESETB, 0, "nl_pulse3_end");
        expect_at(76,  S_RESETB, 1, "nl_wait3");
        expect_at(107, S_FAULT,  0, "nl_fault_not_early");
        expect_at(108, S_FAULT,  1, "nl_fault");
        expect_at(108, S_RESETB, 0, "nl_fault_resetb");
        expect_at(150, S_FAULT,  1, "nl_fault_held");
        expect_at(150, S_RESETB, 0, "nl_resetb_held");
        expect_at(150, S_READY,  0, "nl_ready_low");
        expect_at(150, S_PIXRST, 1, "nl_pixrst_high");
        do_reset(1'b0);
        run_to(150);
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
